// File: rtl/mem_pkg.sv
// Shared types and constants for the wait-stated memory responder.
package mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/ram_array.sv
// Synchronous single-port word array; registered read, write-enable, no reset
// so contents survive clr.
module ram_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [0:(1<<ADDR_W)-1];

  // Write port and registered read port share one address.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: samples a read/write request in IDLE, inserts WAIT_CYCLES
// wait states, commits on the edge leaving ACCESS and strobes done for a cycle.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              read,
  input  logic              write,
  output logic [31:0]       MDatain,
  output logic              done,
  output logic              busy,
  output logic              err
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic                is_wr_q, is_wr_d;
  logic [WORD_W-1:0]   mdata_q, mdata_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  logic                req_ok_s;
  logic                req_bad_s;
  logic [ADDR_W-1:0]   ram_addr_s;
  logic                ram_we_s;
  logic [WORD_W-1:0]   ram_rdata_s;

  assign req_ok_s  = read ^ write;
  assign req_bad_s = read & write;

  // The array reads the live address while idle so the word is ready by ACCESS
  // even with no wait states; afterwards only the latched address is used.
  assign ram_addr_s = (state_q == ST_IDLE) ? addr : addr_q;
  assign ram_we_s   = (state_q == ST_ACCESS) && is_wr_q;

  ram_array #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we_s),
    .addr_i  (ram_addr_s),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata_s)
  );

  // Next-state logic for the request FSM and its latched operands.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    is_wr_d = is_wr_q;
    mdata_d = mdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_ok_s) begin
          addr_d  = addr;
          wdata_d = wdata;
          is_wr_d = write;
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = ST_ACCESS;
            cnt_d   = 4'd0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACCESS: begin
        state_d = ST_DONE;
        if (!is_wr_q) begin
          mdata_d = ram_rdata_s;
        end else begin
          mdata_d = mdata_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    done_d = (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE);
    err_d  = (state_q == ST_IDLE) && req_bad_s;
  end

  // State and output registers; clr aborts any operation in flight.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      is_wr_q <= 1'b0;
      mdata_q <= 32'd0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      mdata_q <= mdata_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign MDatain = mdata_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: two responders (2 and 0 wait states) checked against a
// transaction-level memory model kept in associative arrays.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        clr2, clr0;
  logic [8:0]  addr2, addr0;
  logic [31:0] wdata2, wdata0;
  logic        rd2, wr2, rd0, wr0;
  logic [31:0] md2, md0;
  logic        done2, busy2, err2, done0, busy0, err0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(9), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .clr(clr2), .addr(addr2), .wdata(wdata2), .read(rd2), .write(wr2),
    .MDatain(md2), .done(done2), .busy(busy2), .err(err2)
  );

  mem_responder #(.ADDR_W(9), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .clr(clr0), .addr(addr0), .wdata(wdata0), .read(rd0), .write(wr0),
    .MDatain(md0), .done(done0), .busy(busy0), .err(err0)
  );

  // sel = 0 addresses the 2-wait instance, sel = 1 the zero-wait instance
  bit          sel;
  logic [2:0]  o_flags;
  logic [31:0] o_md;
  assign o_flags = sel ? {busy0, done0, err0} : {busy2, done2, err2};
  assign o_md    = sel ? md0 : md2;

  logic [31:0] ref_mem [int];
  logic [31:0] exp_md [2];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic int mkey(input bit s, input logic [8:0] a);
    return (s ? 1024 : 0) + int'(a);
  endfunction

  task automatic drive_req(input bit rd, input bit wr, input logic [8:0] a, input logic [31:0] d);
    if (sel) begin
      rd0 = rd; wr0 = wr; addr0 = a; wdata0 = d;
    end else begin
      rd2 = rd; wr2 = wr; addr2 = a; wdata2 = d;
    end
  endtask

  // Called at a negedge with the selected DUT idle; returns at a negedge, idle.
  task automatic run_op(input bit is_wr, input logic [8:0] a, input logic [31:0] d,
                        input bit hold, input string name);
    int          w = sel ? 0 : 2;
    logic [31:0] md_before = exp_md[sel];
    logic [31:0] md_after;
    logic [2:0]  exp_flags;
    logic [31:0] exp_now;
    if (is_wr) ref_mem[mkey(sel, a)] = d;
    else       exp_md[sel] = ref_mem[mkey(sel, a)];
    md_after = exp_md[sel];
    drive_req(!is_wr, is_wr, a, d);
    @(posedge clk); #1;
    if (!hold) drive_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 9'($urandom), $urandom);
    for (int k = 0; k <= w + 2; k++) begin
      if (k > 0) @(posedge clk);
      @(negedge clk);
      exp_flags = (k == w + 2) ? 3'b000 : ((k == w + 1) ? 3'b110 : 3'b100);
      exp_now   = (k >= w + 1) ? md_after : md_before;
      n_checks++;
      if (o_flags !== exp_flags) begin
        n_fail++;
        $display("FAIL %s flags k=%0d: got busy/done/err=%b expected %b", name, k, o_flags, exp_flags);
      end
      n_checks++;
      if (o_md !== exp_now) begin
        n_fail++;
        $display("FAIL %s MDatain k=%0d: got %h expected %h", name, k, o_md, exp_now);
      end
    end
    drive_req(1'b0, 1'b0, a, d);
  endtask

  task automatic test_reset();
    clr2 = 1'b1; clr0 = 1'b1;
    rd2 = 1'b0; wr2 = 1'b0; addr2 = 9'd0; wdata2 = 32'd0;
    rd0 = 1'b0; wr0 = 1'b0; addr0 = 9'd0; wdata0 = 32'd0;
    exp_md[0] = 32'd0; exp_md[1] = 32'd0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #0;
      n_checks++;
      if ({o_md, o_flags} !== 35'd0) begin
        n_fail++;
        $display("FAIL reset sel=%0d: got md=%h flags=%b expected all zero", s, o_md, o_flags);
      end
    end
    clr2 = 1'b0; clr0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    sel = 1'b0;
    run_op(1'b1, 9'd5, 32'hDEADBEEF, 1'b0, "write5");
    run_op(1'b0, 9'd5, 32'd0, 1'b0, "read5");
    run_op(1'b1, 9'd7, 32'h0BADF00D, 1'b0, "write7_holds_md");
    run_op(1'b1, 9'd511, 32'hFFFF0001, 1'b1, "write511_held");
    run_op(1'b0, 9'd511, 32'd0, 1'b1, "read511_b2b");
  endtask

  task automatic test_illegal();
    sel = 1'b0;
    drive_req(1'b1, 1'b1, 9'd5, 32'h11111111);
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (o_flags !== 3'b001 || o_md !== exp_md[0]) begin
      n_fail++;
      $display("FAIL illegal strobe: got flags=%b md=%h expected 001 md=%h", o_flags, o_md, exp_md[0]);
    end
    drive_req(1'b0, 1'b0, 9'd5, 32'd0);
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (o_flags !== 3'b000) begin
      n_fail++;
      $display("FAIL illegal one_cycle: got flags=%b expected 000", o_flags);
    end
    run_op(1'b0, 9'd5, 32'd0, 1'b0, "read5_after_illegal");
  endtask

  task automatic test_abort();
    sel = 1'b0;
    drive_req(1'b0, 1'b1, 9'd7, 32'h12345678);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 9'd0, 32'd0);
    @(negedge clk);
    n_checks++;
    if (o_flags !== 3'b100) begin
      n_fail++;
      $display("FAIL abort busy_before: got flags=%b expected 100", o_flags);
    end
    clr2 = 1'b1;
    exp_md[0] = 32'd0;
    #1;
    n_checks++;
    if (o_flags !== 3'b000 || o_md !== 32'd0) begin
      n_fail++;
      $display("FAIL abort async: got flags=%b md=%h expected 000 md=0", o_flags, o_md);
    end
    @(negedge clk);
    clr2 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (o_flags !== 3'b000) begin
        n_fail++;
        $display("FAIL abort quiet k=%0d: got flags=%b expected 000", k, o_flags);
      end
    end
    run_op(1'b0, 9'd7, 32'd0, 1'b0, "read7_after_abort");
    run_op(1'b0, 9'd5, 32'd0, 1'b0, "read5_after_clr");
  endtask

  task automatic test_zero_wait();
    sel = 1'b1;
    @(negedge clk);
    run_op(1'b1, 9'd0, 32'hA5A5A5A5, 1'b1, "z_write0");
    run_op(1'b0, 9'd0, 32'd0, 1'b1, "z_read0");
  endtask

  task automatic test_random();
    logic [8:0]  a;
    logic [31:0] d;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      @(negedge clk);
      for (int i = 0; i < 30; i++) begin
        a = ($urandom_range(0, 3) == 0) ? 9'd511 : 9'($urandom_range(0, 7));
        d = $urandom;
        if ($urandom_range(0, 1) == 1 && ref_mem.exists(mkey(sel, a)))
          run_op(1'b0, a, d, 1'($urandom_range(0, 1)), "rand_read");
        else
          run_op(1'b1, a, d, 1'($urandom_range(0, 1)), "rand_write");
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_illegal();
    test_abort();
    test_zero_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 9, meaning address width; array depth is 2^ADDR_W words.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, meaning wait states inserted before each access (legal range 0..15).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port clr, input, 1, meaning reset, asynchronous and active-high.
REQ-005 The block SHALL have port addr, input, ADDR_W, meaning word address driven from the MAR.
REQ-006 The block SHALL have port wdata, input, 32, meaning write data driven from the MDR output.
REQ-007 The block SHALL have port read, input, 1, meaning read request level.
REQ-008 The block SHALL have port write, input, 1, meaning write request level.
REQ-009 The block SHALL have port MDatain, output, 32, meaning read data returned to the MDR memory-side mux input.
REQ-010 The block SHALL have port done, output, 1, meaning one-cycle completion strobe.
REQ-011 The block SHALL have port busy, output, 1, meaning high whenever the FSM is not in IDLE.
REQ-012 The block SHALL have port err, output, 1, meaning one-cycle strobe for an illegal request.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT, ACCESS and DONE.
REQ-014 In IDLE, on a rising edge with exactly one of read/write high, the block SHALL latch addr, wdata and the operation, and leave IDLE (to WAIT if WAIT_CYCLES>0, else to ACCESS).
REQ-015 The block SHALL remain in WAIT for exactly WAIT_CYCLES cycles, counted by a down-counter, then enter ACCESS.
REQ-016 The array write, or the MDatain update on a read, SHALL commit on the edge leaving ACCESS, which is the same edge that enters DONE.
REQ-017 done SHALL be high for exactly one cycle, beginning WAIT_CYCLES+1 edges after the request-sampling edge.
REQ-018 DONE SHALL return to IDLE unconditionally on the next edge; giving a minimum request-to-request period of WAIT_CYCLES+3 cycles.
REQ-019 Requests SHALL be sampled only in IDLE; read, write, addr and wdata changes while busy SHALL be ignored.
REQ-020 In IDLE, with read and write both high, the block SHALL assert err for one cycle, stay in IDLE and perform no access.
REQ-021 MDatain SHALL hold its last read value until the next read commits; writes SHALL NOT change MDatain.
REQ-022 A read of an address written earlier SHALL return the last written value; write-then-read of the same address back-to-back SHALL return the new data.

Reset
REQ-023 On clr high, the block SHALL asynchronously enter IDLE with done=0, busy=0, err=0, MDatain=0 and the wait counter at 0.
REQ-024 clr asserted before the commit edge SHALL abort the operation, with no array write and no done.
REQ-025 Array contents SHALL NOT be cleared by clr.

Structure
REQ-026 Package mem_pkg SHALL hold the FSM state enum and the WORD_W=32 constant.
REQ-027 Storage SHALL be a sub-module named ram_array, a synchronous 2^ADDR_W x 32 single-port array with write-enable.

Verification
REQ-028 Write scenario: write 0xDEADBEEF to addr 5 with WAIT_CYCLES=2 -> busy high from the next cycle; done high for one cycle exactly 3 edges after sampling; MDatain unchanged.
REQ-029 Read scenario: read addr 5 -> done after 3 edges with MDatain=0xDEADBEEF, held until the next read.
REQ-030 Illegal request: read=write=1 in IDLE -> err=1 for one cycle, busy stays 0, addr 5 still reads 0xDEADBEEF.
REQ-031 Abort scenario: clr pulsed during WAIT of a write of 0x12345678 to addr 7 -> immediate IDLE, done never asserted, addr 7 retains its prior value.
REQ-032 Zero-wait scenario: WAIT_CYCLES=0, back-to-back write 0xA5A5A5A5 to addr 0 then read addr 0, with request held while busy -> each done 1 edge after sampling, second request sampled only after DONE, read returns 0xA5A5A5A5.
